// File: rtl/ekf_sequencer.sv
// ekf_sequencer: schedules red/IR channels over one shared EKF datapath,
// owns per-channel X/P state and registers the fused result.
module ekf_sequencer #(
  parameter int          SETTLE = 2,
  parameter int          FRAC   = 8,
  parameter logic [15:0] P_INIT = 16'h0100
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [47:0]   in_rz,
  input  logic [47:0]   in_iz,
  input  logic          clr_state,
  output logic          dp_sel,
  output logic [95:0]   dp_xp,
  output logic [575:0]  dp_p,
  output logic [47:0]   dp_z,
  input  logic [95:0]   dp_xn,
  input  logic [1151:0] dp_pn,
  output logic [191:0]  fu_rp,
  output logic [191:0]  fu_ip,
  output logic [95:0]   fu_rx,
  output logic [95:0]   fu_ix,
  input  logic [191:0]  fu_xf,
  input  logic [191:0]  fu_pf,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [191:0]  xf,
  output logic [191:0]  pf,
  output logic          sat_sticky
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CLAST = CW'(SETTLE - 1);

  function automatic logic [575:0] p_rst_vec();
    logic [575:0] v;
    v = '0;
    for (int k = 0; k < 36; k += 7) v[k*16 +: 16] = P_INIT;
    return v;
  endfunction

  localparam logic [575:0] P_RST = p_rst_vec();

  // {saturated, value} of a 32-bit product scaled back to 16 bits
  function automatic logic [16:0] sat16(input logic [31:0] v);
    logic signed [31:0] s;
    s = $signed(v) >>> FRAC;
    if (s > 32'sd32767) return {1'b1, 16'h7FFF};
    if (s < -32'sd32768) return {1'b1, 16'h8000};
    return {1'b0, s[15:0]};
  endfunction

  typedef enum logic [2:0] {IDLE, RUN_R, RUN_I, FUSE, OUT} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [95:0]     rx_q, ix_q;
  logic [575:0]    rp_q, ip_q;
  logic [47:0]     rz_q, iz_q;
  logic [95:0]     fu_rx_q, fu_ix_q;
  logic [191:0]    fu_rp_q, fu_ip_q;
  logic [191:0]    xf_q, pf_q;
  logic            out_valid_q, sat_q, clr_pend_q;
  logic            last, accept, clr_now, cap;
  logic [16:0]     wb [36];
  logic [575:0]    pn_sat;
  logic [191:0]    pn_diag;
  logic            sat_any;

  assign last     = (cnt_q == CLAST);
  assign in_ready = (state_q == IDLE) && !clr_pend_q && !clr_state;
  assign accept   = in_valid && in_ready;
  assign clr_now  = (state_q == IDLE) && (clr_state || clr_pend_q);
  assign cap      = ((state_q == RUN_R) || (state_q == RUN_I)) && last;

  assign dp_sel     = (state_q == RUN_I);
  assign dp_xp      = dp_sel ? ix_q : rx_q;
  assign dp_p       = dp_sel ? ip_q : rp_q;
  assign dp_z       = dp_sel ? iz_q : rz_q;
  assign fu_rp      = fu_rp_q;
  assign fu_ip      = fu_ip_q;
  assign fu_rx      = fu_rx_q;
  assign fu_ix      = fu_ix_q;
  assign xf         = xf_q;
  assign pf         = pf_q;
  assign out_valid  = out_valid_q;
  assign sat_sticky = sat_q;

  // scale/saturate Pn for write-back and pick out its raw diagonal
  always_comb begin
    pn_sat  = '0;
    pn_diag = '0;
    sat_any = 1'b0;
    for (int k = 0; k < 36; k++) begin
      wb[k] = sat16(dp_pn[k*32 +: 32]);
      pn_sat[k*16 +: 16] = wb[k][15:0];
      sat_any = sat_any | wb[k][16];
    end
    for (int j = 0; j < 6; j++) pn_diag[j*32 +: 32] = dp_pn[j*224 +: 32];
  end

  // state and settle-counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state: each busy phase lasts SETTLE cycles
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (accept) begin
        state_d = RUN_R;
        cnt_d   = '0;
      end
      RUN_R, RUN_I, FUSE: begin
        if (last) begin
          cnt_d = '0;
          unique case (state_q)
            RUN_R:   state_d = RUN_I;
            RUN_I:   state_d = FUSE;
            default: state_d = OUT;
          endcase
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      OUT: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // channel state, z latches, fusion inputs, sticky flags and clears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q       <= '0;
      ix_q       <= '0;
      rp_q       <= P_RST;
      ip_q       <= P_RST;
      rz_q       <= '0;
      iz_q       <= '0;
      fu_rx_q    <= '0;
      fu_ix_q    <= '0;
      fu_rp_q    <= '0;
      fu_ip_q    <= '0;
      sat_q      <= 1'b0;
      clr_pend_q <= 1'b0;
    end else begin
      if (accept) begin
        rz_q <= in_rz;
        iz_q <= in_iz;
      end
      if ((state_q == RUN_R) && last) begin
        rx_q    <= dp_xn;
        rp_q    <= pn_sat;
        fu_rx_q <= dp_xn;
        fu_rp_q <= pn_diag;
      end
      if ((state_q == RUN_I) && last) begin
        ix_q    <= dp_xn;
        ip_q    <= pn_sat;
        fu_ix_q <= dp_xn;
        fu_ip_q <= pn_diag;
      end
      if (cap) sat_q <= sat_q | sat_any;
      if (clr_now) begin
        rx_q       <= '0;
        ix_q       <= '0;
        rp_q       <= P_RST;
        ip_q       <= P_RST;
        sat_q      <= 1'b0;
        clr_pend_q <= 1'b0;
      end else if (clr_state) begin
        clr_pend_q <= 1'b1;
      end
    end
  end

  // fused result register and output handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xf_q        <= '0;
      pf_q        <= '0;
      out_valid_q <= 1'b0;
    end else if ((state_q == FUSE) && last) begin
      xf_q        <= fu_xf;
      pf_q        <= fu_pf;
      out_valid_q <= 1'b1;
    end else if ((state_q == OUT) && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ekf_sequencer.sv
// tb_ekf_sequencer: directed + randomized bench for ekf_sequencer,
// with datapath/fusion stand-ins and an integer reference model.
module tb_ekf_sequencer;

  localparam int FRAC = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [47:0]   in_rz = '0;
  logic [47:0]   in_iz = '0;
  logic          clr_state = 1'b0;
  logic          dp_sel;
  logic [95:0]   dp_xp;
  logic [575:0]  dp_p;
  logic [47:0]   dp_z;
  logic [95:0]   dp_xn;
  logic [1151:0] dp_pn;
  logic [191:0]  fu_rp, fu_ip;
  logic [95:0]   fu_rx, fu_ix;
  logic [191:0]  fu_xf, fu_pf;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [191:0]  xf, pf;
  logic          sat_sticky;

  ekf_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rz(in_rz), .in_iz(in_iz), .clr_state(clr_state),
    .dp_sel(dp_sel), .dp_xp(dp_xp), .dp_p(dp_p), .dp_z(dp_z),
    .dp_xn(dp_xn), .dp_pn(dp_pn),
    .fu_rp(fu_rp), .fu_ip(fu_ip), .fu_rx(fu_rx), .fu_ix(fu_ix),
    .fu_xf(fu_xf), .fu_pf(fu_pf),
    .out_valid(out_valid), .out_ready(out_ready),
    .xf(xf), .pf(pf), .sat_sticky(sat_sticky)
  );

  always #5 clk = ~clk;

  // per-channel Pn overrides used to force specific write-back values
  bit          ovr_en [2][36];
  logic [31:0] ovv    [2][36];

  // datapath stand-in: Xn = X + z (padded), Pn = P << FRAC
  always_comb begin
    dp_xn = dp_xp;
    dp_pn = '0;
    for (int i = 0; i < 3; i++)
      dp_xn[i*16 +: 16] = dp_xp[i*16 +: 16] + dp_z[i*16 +: 16];
    for (int k = 0; k < 36; k++)
      dp_pn[k*32 +: 32] = ovr_en[dp_sel][k] ? ovv[dp_sel][k]
        : ({{16{dp_p[k*16+15]}}, dp_p[k*16 +: 16]} << FRAC);
  end

  // fusion stand-in: elementwise sums of the two channels
  always_comb begin
    fu_xf = '0;
    fu_pf = '0;
    for (int j = 0; j < 6; j++) begin
      fu_xf[j*32 +: 32] = {{16{fu_rx[j*16+15]}}, fu_rx[j*16 +: 16]}
                        + {{16{fu_ix[j*16+15]}}, fu_ix[j*16 +: 16]};
      fu_pf[j*32 +: 32] = fu_rp[j*32 +: 32] + fu_ip[j*32 +: 32];
    end
  end

  // reference model state
  shortint      mX [2][6];
  shortint      mP [2][36];
  bit           msat;
  logic [191:0] exf, epf;
  logic [191:0] first_xf, first_pf;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [575:0] obs,
                     input logic [575:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    msat = 1'b0;
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 6; i++) mX[c][i] = 0;
      for (int k = 0; k < 36; k++) mP[c][k] = (k % 7 == 0) ? 16'sh0100 : 0;
    end
  endtask

  task automatic clr_ovr();
    for (int c = 0; c < 2; c++)
      for (int k = 0; k < 36; k++) begin
        ovr_en[c][k] = 1'b0;
        ovv[c][k] = '0;
      end
  endtask

  // one full sample: both channels updated, fused result predicted
  task automatic model_sample(input logic [47:0] rz, input logic [47:0] iz);
    int      diag [2][6];
    int      zv [3];
    int      pn, sh;
    logic [47:0] z;
    for (int c = 0; c < 2; c++) begin
      z = (c == 0) ? rz : iz;
      for (int i = 0; i < 3; i++) zv[i] = int'($signed(z[i*16 +: 16]));
      for (int i = 0; i < 3; i++) mX[c][i] = shortint'(int'(mX[c][i]) + zv[i]);
      for (int k = 0; k < 36; k++) begin
        pn = ovr_en[c][k] ? int'(ovv[c][k]) : int'(mP[c][k]) * (1 << FRAC);
        if (k % 7 == 0) diag[c][k/7] = pn;
        sh = pn >>> FRAC;
        if (sh > 32767) begin
          mP[c][k] = 32767;
          msat = 1'b1;
        end else if (sh < -32768) begin
          mP[c][k] = -32768;
          msat = 1'b1;
        end else begin
          mP[c][k] = shortint'(sh);
        end
      end
    end
    for (int j = 0; j < 6; j++) begin
      exf[j*32 +: 32] = int'(mX[0][j]) + int'(mX[1][j]);
      epf[j*32 +: 32] = diag[0][j] + diag[1][j];
    end
  endtask

  function automatic logic [95:0] pack_x(input int c);
    logic [95:0] v;
    for (int i = 0; i < 6; i++) v[i*16 +: 16] = mX[c][i];
    return v;
  endfunction

  function automatic logic [575:0] pack_p(input int c);
    logic [575:0] v;
    for (int k = 0; k < 36; k++) v[k*16 +: 16] = mP[c][k];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // offer a sample and wait (bounded) for acceptance; returns after edge E
  task automatic send(input logic [47:0] rz, input logic [47:0] iz);
    int n = 0;
    in_rz = rz;
    in_iz = iz;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("accept_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model_sample(rz, iz);
  endtask

  // wait (bounded) for the result, optionally stall it, then hand it off
  task automatic finish_sample(input int bp);
    int n = 0;
    out_ready = (bp == 0);
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk("ov_rise", out_valid, 1'b1);
    chk("xf", xf, exf);
    chk("pf", pf, epf);
    for (int i = 0; i < bp; i++) begin
      tick();
      chk("bp_ov", out_valid, 1'b1);
      chk("bp_xf", xf, exf);
      chk("bp_pf", pf, epf);
      chk("bp_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    chk("ov_fall", out_valid, 1'b0);
  endtask

  function automatic logic [47:0] rnd_z();
    return {16'($urandom), 16'($urandom), 16'($urandom)};
  endfunction

  initial begin
    logic [575:0] pr;
    logic [47:0]  rz, iz;
    int           nk;
    clr_ovr();
    model_clear();
    pr = pack_p(0);

    // reset state
    repeat (2) tick();
    chk("rst_ov", out_valid, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_sel", dp_sel, 1'b0);
    chk("rst_sat", sat_sticky, 1'b0);
    chk("rst_xf", xf, '0);
    chk("rst_pf", pf, '0);
    chk("rst_furp", fu_rp, '0);
    chk("rst_furx", fu_rx, '0);
    chk("rst_z", dp_z, '0);
    chk("rst_x", dp_xp, '0);
    chk("rst_p", dp_p, pr);
    rst_n = 1'b1;
    tick();

    // first sample with cycle-exact timing
    in_rz = {16'd3, 16'd2, 16'd1};
    in_iz = {16'd6, 16'd5, 16'd4};
    in_valid = 1'b1;
    #1;
    chk("t1_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model_sample({16'd3, 16'd2, 16'd1}, {16'd6, 16'd5, 16'd4});
    for (int i = 0; i < 6; i++) begin
      chk("t1_busy_ready", in_ready, 1'b0);
      chk("t1_sel", dp_sel, (i == 2 || i == 3));
      chk("t1_ov_low", out_valid, 1'b0);
      if (i == 2) chk("t1_fu_rx", fu_rx, pack_x(0));
      if (i == 4) chk("t1_fu_ix", fu_ix, pack_x(1));
      tick();
    end
    chk("t1_ov", out_valid, 1'b1);
    chk("t1_out_ready", in_ready, 1'b0);
    chk("t1_xf", xf, {96'd0, 32'd9, 32'd7, 32'd5});
    chk("t1_pf", pf, {6{32'h0002_0000}});
    first_xf = exf;
    first_pf = epf;
    tick();
    chk("t1_ov_fall", out_valid, 1'b0);
    chk("t1_ready_back", in_ready, 1'b1);

    // write-back scaling and saturation
    ovr_en[0][0] = 1'b1;
    ovv[0][0] = 32'h0001_2345;
    send(rnd_z(), rnd_z());
    finish_sample(0);
    chk("wb_p0", dp_p[15:0], 16'h0123);
    chk("wb_sat0", sat_sticky, 1'b0);
    chk("wb_pfull", dp_p, pack_p(0));
    clr_ovr();
    ovr_en[0][7] = 1'b1;
    ovv[0][7] = 32'h0100_0000;
    ovr_en[0][14] = 1'b1;
    ovv[0][14] = 32'hFF00_0000;
    send(rnd_z(), rnd_z());
    finish_sample(0);
    chk("wb_p7", dp_p[7*16 +: 16], 16'h7FFF);
    chk("wb_p14", dp_p[14*16 +: 16], 16'h8000);
    chk("wb_sat1", sat_sticky, 1'b1);
    clr_ovr();

    // backpressure
    send(rnd_z(), rnd_z());
    finish_sample(10);
    chk("bp_ready_after", in_ready, 1'b1);

    // deferred clear while busy
    send(rnd_z(), rnd_z());
    tick();
    tick();
    clr_state = 1'b1;
    tick();
    clr_state = 1'b0;
    finish_sample(0);
    chk("clr_idle_ready", in_ready, 1'b0);
    model_clear();
    tick();
    chk("clr_x", dp_xp, '0);
    chk("clr_p0", dp_p[15:0], 16'h0100);
    chk("clr_p1", dp_p[31:16], 16'h0000);
    chk("clr_pfull", dp_p, pack_p(0));
    chk("clr_sat", sat_sticky, 1'b0);
    chk("clr_ready", in_ready, 1'b1);

    // reset in the middle of a sample
    send(rnd_z(), rnd_z());
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mr_ov", out_valid, 1'b0);
    chk("mr_sel", dp_sel, 1'b0);
    model_clear();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("mr_ov_quiet", out_valid, 1'b0);
    end
    send({16'd3, 16'd2, 16'd1}, {16'd6, 16'd5, 16'd4});
    finish_sample(0);
    chk("mr_xf_same", xf, first_xf);
    chk("mr_pf_same", pf, first_pf);

    // clear and valid together: clear first, sample one cycle later
    rz = rnd_z();
    iz = rnd_z();
    in_rz = rz;
    in_iz = iz;
    clr_state = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("sim_ready_low", in_ready, 1'b0);
    tick();
    model_clear();
    clr_state = 1'b0;
    #1;
    chk("sim_ready_high", in_ready, 1'b1);
    chk("sim_x_clear", dp_xp, '0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model_sample(rz, iz);
    finish_sample(0);

    // randomized samples with random Pn overrides and stalls
    for (int s = 0; s < 20; s++) begin
      clr_ovr();
      for (int c = 0; c < 2; c++) begin
        nk = $urandom_range(0, 2);
        for (int m = 0; m < nk; m++) begin
          int k;
          k = $urandom_range(0, 35);
          ovr_en[c][k] = 1'b1;
          ovv[c][k] = $urandom;
        end
      end
      send(rnd_z(), rnd_z());
      finish_sample($urandom_range(0, 3));
      chk("rnd_x", dp_xp, pack_x(0));
      chk("rnd_p", dp_p, pack_p(0));
      chk("rnd_sat", sat_sticky, msat);
    end
    clr_ovr();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ekf_sequencer.md
# ekf_sequencer

Sequencer and scheduler for the dual-channel (red / IR) extended Kalman filter. It owns the per-channel state vector X and covariance P registers and time-multiplexes one shared, purely combinational predictor+measurement datapath between the two channels. It then drives the combinational fusion unit and returns one registered fused result per accepted measurement pair.

## Interface
- `SETTLE`, 2: cycles allowed for each combinational path (datapath or fusion) to settle before capture; must be ≥1.
- `FRAC`, 8: arithmetic right shift applied to 32-bit Pn before it is written back as 16-bit P.
- `P_INIT`, 16'h0100: reset/clear value of the P diagonal (indices 0,7,14,21,28,35); all off-diagonal entries reset to 0.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1 / `in_ready` out 1: measurement handshake.
- `in_rz` in 48: red z1..z3, 3×16 signed, z1 in bits [15:0].
- `in_iz` in 48: IR z1..z3, same packing.
- `clr_state` in 1: one-cycle pulse that reinitialises both channels' X, P and `sat_sticky`.
- `dp_sel` out 1: channel on the shared datapath (0 red, 1 IR).
- `dp_xp` out 96: X, 6×16 signed.
- `dp_p` out 576: P, 36×16 signed, row-major.
- `dp_z` out 48: z of the selected channel.
- `dp_xn` in 96: updated X from the datapath.
- `dp_pn` in 1152: updated P from the datapath, 36×32 signed.
- `fu_rp` out 192 / `fu_ip` out 192: captured 32-bit Pn diagonals for red / IR.
- `fu_rx` out 96 / `fu_ix` out 96: captured Xn for red / IR.
- `fu_xf` in 192 / `fu_pf` in 192: fusion results, 6×32 signed.
- `out_valid` out 1 / `out_ready` in 1: result handshake.
- `xf` out 192 / `pf` out 192: registered fused X and P diagonal.
- `sat_sticky` out 1: set when any P write-back saturated.

## Operation
- FSM states are IDLE, RUN_R, RUN_I, FUSE, OUT. A counter `cnt` runs 0..SETTLE-1 in RUN_R, RUN_I and FUSE.
- **IDLE:**
  - `in_ready`=1 only when no clear is pending.
  - On `in_valid&&in_ready`, latch `in_rz` and `in_iz`, then go to RUN_R with `cnt`=0.
- **RUN_R:**
  - `dp_sel`=0; `dp_xp`, `dp_p` and `dp_z` are driven from the red registers and stay stable for the whole state.
  - At `cnt`=SETTLE-1:
    - write `dp_xn` into red X;
    - write sat16(`dp_pn[k]` >>> FRAC) into red P[k] for k=0..35;
    - copy `dp_xn` into `fu_rx` and the Pn diagonal (raw 32-bit) into `fu_rp`;
    - go to RUN_I.
- **RUN_I:** the same sequence for the IR channel (`dp_sel`=1, `in_iz`, `fu_ix`, `fu_ip`), then go to FUSE.
- **FUSE:** at `cnt`=SETTLE-1, register `fu_xf`→`xf` and `fu_pf`→`pf`, set `out_valid`, go to OUT.
- **OUT:**
  - Hold `xf`, `pf` and `out_valid` until `out_ready`.
  - On `out_valid&&out_ready`, clear `out_valid` and return to IDLE.
  - `in_ready` stays 0 in OUT, so there is no overlap between samples.
- **sat16 rule:** a shifted value >32767 becomes 16'h7FFF; a value < -32768 becomes 16'h8000. Any saturation sets `sat_sticky`.
- **`clr_state`:**
  - In IDLE it takes effect on that edge: X=0, P=P_INIT diagonal, `sat_sticky`=0.
  - If `clr_state` and `in_valid` arrive together in IDLE, the clear wins and the sample is not accepted (`in_ready` is forced low that cycle).
  - When busy, a `clr_pend` flag is set. The clear is applied in the first IDLE cycle, and `in_ready`=0 in that cycle.
  - A `sat_sticky` set by the in-flight sample is cleared by the deferred clear.
  - A clear never alters `xf`/`pf` once they are captured.
- The `fu_*` outputs hold their last captured values between samples.

## Timing
- **Reset values** (`rst_n`=0 at any time, FSM → IDLE):
  - `out_valid`=0, `in_ready`=1, `dp_sel`=0, `sat_sticky`=0, `clr_pend`=0;
  - `xf`, `pf`, `fu_*` and the z latches are 0; X=0; P=P_INIT diagonal.
  - An in-flight sample is discarded.
- **Latency:**
  - Acceptance edge is E. `out_valid` rises on edge E+3·SETTLE, i.e. E+6 for SETTLE=2.
  - Red capture occurs at E+SETTLE and IR capture at E+2·SETTLE.
- **Throughput:** at most one sample per 3·SETTLE+2 cycles when `out_ready` is tied high.
- The `dp_*` outputs change only on state transitions, so the datapath sees SETTLE full cycles of stable input.

## Test plan
- **Reset:** release `rst_n`; apply `in_valid`=1 with in_rz={3,2,1}, in_iz={6,5,4} and a datapath model returning Xn=X+z-padded, Pn=P<<FRAC. Require `in_ready`=0 during E+1..E+7, `out_valid` high at E+6, and `dp_sel` = 0 for 2 cycles then 1 for 2 cycles.
- **Write-back:** `dp_pn[0]`=32'h0001_2345 → red P[0]=16'h0123 and `sat_sticky`=0. `dp_pn[7]`=32'h0100_0000 → P[7]=16'h7FFF and `sat_sticky`=1. `dp_pn[14]`=32'hFF00_0000 → P[14]=16'h8000.
- **Backpressure:** hold `out_ready`=0 for 10 cycles. `xf`/`pf` must stay stable and `out_valid` must stay 1. `in_ready` stays 0 until the cycle after `out_ready`.
- **Clear:** pulse `clr_state` at E+3. Result is still delivered. In the IDLE cycle after handoff `in_ready`=0, then X=0, P[0]=16'h0100, P[1]=0, `sat_sticky`=0.
- **Reset mid-op:** assert `rst_n`=0 at E+4. `out_valid` stays 0, the next sample sees the initial state, and its result matches the reset scenario.
- **Simultaneous:** `clr_state` and `in_valid` in the same IDLE cycle → the sample is not accepted and is accepted one cycle later against the cleared state.
